// File: rtl/polyz_pack_stream_if.sv
// polyz_pack_stream_if: coefficient-in and byte-out valid/ready streams of the z-polynomial packer
interface polyz_pack_stream_if #(parameter int COEF_W = 32);
  logic              coef_valid;
  logic              coef_ready;
  logic [COEF_W-1:0] coef_data;
  logic              byte_valid;
  logic              byte_ready;
  logic [7:0]        byte_data;
  logic              byte_last;
  modport master(input coef_valid, coef_data, byte_ready, output coef_ready, byte_valid, byte_data, byte_last);
  modport slave(output coef_valid, coef_data, byte_ready, input coef_ready, byte_valid, byte_data, byte_last);
endinterface

// File: rtl/polyz_pack_stream.sv
// polyz_pack_stream: streams t = GAMMA1 - a, Z bits per coefficient, LSB-first into bytes
// Optional coefficient range flag enabled by defining POLYZ_RANGE_CHECK_EN.
module polyz_pack_stream #(
  parameter int N      = 256,
  parameter int COEF_W = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic gamma1_sel,
  output logic busy,
  output logic done,
  output logic range_err,
  polyz_pack_stream_if.master s
);
  localparam int CW = $clog2(N + 1);
  localparam int BW = $clog2(N * 20 / 8 + 1);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;
  state_t state, state_n;
  logic [31:0] acc, acc_n, sh;
  logic [4:0] cnt, cnt_n, cs;
  logic [CW-1:0] ccnt, ccnt_n;
  logic [BW-1:0] bcnt, bcnt_n, last_idx;
  logic z20, z20_n, coef_hs, byte_hs, go;
  logic [19:0] g20, d, t;
  always_comb begin
    g20 = z20 ? 20'h80000 : 20'h20000;
    d = g20 - s.coef_data[19:0];
    t = z20 ? d : {2'b0, d[17:0]};
    s.coef_ready = (state == RUN) && (cnt < 5'd8);
    s.byte_valid = (state == RUN || state == DRAIN) && (cnt >= 5'd8);
    s.byte_data = acc[7:0];
    last_idx = z20 ? BW'(N * 20 / 8 - 1) : BW'(N * 18 / 8 - 1);
    s.byte_last = s.byte_valid && (bcnt == last_idx);
    coef_hs = s.coef_valid && s.coef_ready;
    byte_hs = s.byte_valid && s.byte_ready;
    go = (state == IDLE) && start;
    busy = state != IDLE;
    done = state == FIN;
    // shift out first, then insert at the post-shift bit position
    sh = byte_hs ? acc >> 8 : acc;
    cs = byte_hs ? cnt - 5'd8 : cnt;
    acc_n = go ? 32'd0 : coef_hs ? sh | ({12'd0, t} << cs) : sh;
    cnt_n = go ? 5'd0 : coef_hs ? cs + (z20 ? 5'd20 : 5'd18) : cs;
    ccnt_n = go ? '0 : ccnt + CW'(coef_hs);
    bcnt_n = go ? '0 : bcnt + BW'(byte_hs);
    z20_n = go ? gamma1_sel : z20;
    state_n = state;
    if (go) state_n = RUN;
    else if (state == RUN && coef_hs && ccnt == CW'(N - 1)) state_n = DRAIN;
    else if (state == DRAIN && byte_hs && s.byte_last) state_n = FIN;
    else if (state == FIN) state_n = IDLE;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      acc <= '0;
      cnt <= '0;
      ccnt <= '0;
      bcnt <= '0;
      z20 <= 1'b0;
    end else begin
      state <= state_n;
      acc <= acc_n;
      cnt <= cnt_n;
      ccnt <= ccnt_n;
      bcnt <= bcnt_n;
      z20 <= z20_n;
    end
  end
`ifdef POLYZ_RANGE_CHECK_EN
  logic [COEF_W-1:0] gamma;
  logic oor;
  assign gamma = z20 ? COEF_W'(32'h80000) : COEF_W'(32'h20000);
  assign oor = ($signed(s.coef_data) > $signed(gamma)) || ($signed(s.coef_data) < $signed(COEF_W'(1) - gamma));
  always_ff @(posedge clk) begin
    if (!rst_n) range_err <= 1'b0;
    else if (go) range_err <= 1'b0;
    else if (coef_hs && oor) range_err <= 1'b1;
  end
`else
  assign range_err = 1'b0;
`endif
endmodule

// File: tb/tb_polyz_pack_stream.sv
// tb_polyz_pack_stream: directed checks of the streaming z-polynomial packer
module tb_polyz_pack_stream;
  logic clk = 1'b0;
  logic rst_n, start, gamma1_sel;
  logic busy, done, range_err;
  int checks = 0, errors = 0;
  logic [31:0] coefs [256];
  logic [7:0] got [1024];
  int nbytes, nlast, any_last, last_at, ndone, viol, first_c, first_b, rng_hs, rng_seen;

  polyz_pack_stream_if #(.COEF_W(32)) bus ();
  polyz_pack_stream #(.N(256), .COEF_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .gamma1_sel(gamma1_sel),
    .busy(busy), .done(done), .range_err(range_err), .s(bus.master)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] pat19(input int i);
    logic [7:0] p [5];
    p = '{8'h00, 8'h00, 8'h08, 8'h00, 8'h80};
    return p[i % 5];
  endfunction

  function automatic logic [7:0] pat17(input int i);
    logic [7:0] p [9];
    p = '{8'h00, 8'h00, 8'h02, 8'h00, 8'h08, 8'h00, 8'h20, 8'h00, 8'h80};
    return p[i % 9];
  endfunction

  task automatic fill(input logic [31:0] v);
    for (int i = 0; i < 256; i++) coefs[i] = v;
  endtask

  // drives one polynomial and records the byte stream; abort>0 resets after that many bytes
  task automatic run_poly(input logic g, input bit rnd, input int abort, input bit restart);
    int ci, cyc, done_cyc;
    bit prev_stall;
    logic [7:0] prev_data;
    ci = 0; cyc = 0; done_cyc = 0; prev_stall = 0; prev_data = 0;
    nbytes = 0; nlast = 0; any_last = 0; last_at = -1; ndone = 0; viol = 0;
    first_c = -1; first_b = -1; rng_hs = -1; rng_seen = -1;
    @(negedge clk);
    start = 1'b1; gamma1_sel = g;
    @(posedge clk); #1;
    start = 1'b0;
    while (cyc < 5000) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (restart && cyc == 10) begin start = 1'b1; gamma1_sel = ~g; end
      if (done) begin ndone++; if (done_cyc == 0) done_cyc = cyc; end
      if (ndone > 0 && cyc > done_cyc + 3) break;
      if (range_err && rng_seen < 0) rng_seen = cyc;
      bus.byte_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.coef_valid = ci < 256;
      bus.coef_data = coefs[ci < 256 ? ci : 0];
      if (prev_stall && (!bus.byte_valid || bus.byte_data !== prev_data)) viol++;
      if (bus.byte_valid && first_b < 0) first_b = cyc;
      if (bus.byte_last) any_last++;
      if (bus.coef_valid && bus.coef_ready) begin
        if (first_c < 0) first_c = cyc;
        if (ci == 5) rng_hs = cyc;
        ci++;
      end
      if (bus.byte_valid && bus.byte_ready) begin
        if (nbytes < 1024) got[nbytes] = bus.byte_data;
        if (bus.byte_last) begin nlast++; last_at = nbytes; end
        nbytes++;
      end
      prev_stall = bus.byte_valid && !bus.byte_ready;
      prev_data = bus.byte_data;
      if (abort > 0 && nbytes == abort) begin
        rst_n = 1'b0;
        for (int k = 0; k < 4; k++) begin
          @(negedge clk);
          if (done) ndone++;
          if (bus.byte_last) any_last++;
        end
        rst_n = 1'b1;
        break;
      end
    end
    start = 1'b0;
    bus.coef_valid = 1'b0;
    bus.byte_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; gamma1_sel = 1'b0;
    bus.coef_valid = 1'b0; bus.coef_data = '0; bus.byte_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busy, bus.coef_ready, bus.byte_valid, bus.byte_last, done, range_err, bus.byte_data} !== 14'd0) begin
      errors++;
      $display("FAIL reset outputs got %b want 0", {busy, bus.coef_ready, bus.byte_valid, bus.byte_last, done, range_err, bus.byte_data});
    end
    rst_n = 1'b1;
  endtask

  task automatic test_g19_zero;
    int bad;
    fill(32'd0);
    run_poly(1'b1, 1'b0, 0, 1'b0);
    bad = 0;
    for (int i = 0; i < 640; i++) if (got[i] !== pat19(i)) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL g19_zero bytes bad=%0d want 0 (first5 %h %h %h %h %h)", bad, got[0], got[1], got[2], got[3], got[4]); end
    checks++; if (nbytes != 640) begin errors++; $display("FAIL g19_zero count got %0d want 640", nbytes); end
    checks++; if (last_at != 639 || nlast != 1) begin errors++; $display("FAIL g19_zero last at %0d n=%0d want 639 n=1", last_at, nlast); end
    checks++; if (ndone != 1) begin errors++; $display("FAIL g19_zero done pulses %0d want 1", ndone); end
    checks++; if (first_b - first_c != 1) begin errors++; $display("FAIL g19_zero latency got %0d want 1", first_b - first_c); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL g19_zero busy after done got %b want 0", busy); end
  endtask

  task automatic test_g17_zero;
    int bad;
    fill(32'd0);
    run_poly(1'b0, 1'b0, 0, 1'b0);
    bad = 0;
    for (int i = 0; i < 576; i++) if (got[i] !== pat17(i)) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL g17_zero bytes bad=%0d want 0", bad); end
    checks++; if (nbytes != 576) begin errors++; $display("FAIL g17_zero count got %0d want 576", nbytes); end
    checks++; if (last_at != 575 || ndone != 1) begin errors++; $display("FAIL g17_zero last at %0d done %0d want 575 1", last_at, ndone); end
  endtask

  task automatic test_extremes;
    int bad;
    fill(32'h0008_0000);
    run_poly(1'b1, 1'b0, 0, 1'b0);
    bad = 0;
    for (int i = 0; i < 640; i++) if (got[i] !== 8'h00) bad++;
    checks++; if (bad != 0 || nbytes != 640) begin errors++; $display("FAIL max_coef bad=%0d n=%0d want 0 640", bad, nbytes); end
    checks++; if (rng_seen >= 0) begin errors++; $display("FAIL max_coef range_err seen at %0d want never", rng_seen); end
    fill(32'hFFF8_0001);
    run_poly(1'b1, 1'b0, 0, 1'b0);
    bad = 0;
    for (int i = 0; i < 640; i++) if (got[i] !== 8'hFF) bad++;
    checks++; if (bad != 0 || nbytes != 640) begin errors++; $display("FAIL min_coef bad=%0d n=%0d want 0 640", bad, nbytes); end
    checks++; if (rng_seen >= 0) begin errors++; $display("FAIL min_coef range_err seen at %0d want never", rng_seen); end
  endtask

  task automatic test_backpressure;
    int bad;
    fill(32'd0);
    run_poly(1'b1, 1'b1, 0, 1'b1);
    bad = 0;
    for (int i = 0; i < 640; i++) if (got[i] !== pat19(i)) bad++;
    checks++; if (bad != 0 || nbytes != 640) begin errors++; $display("FAIL backpressure bad=%0d n=%0d want 0 640", bad, nbytes); end
    checks++; if (viol != 0) begin errors++; $display("FAIL hold_stable changes=%0d want 0", viol); end
    checks++; if (last_at != 639 || ndone != 1) begin errors++; $display("FAIL backpressure last %0d done %0d want 639 1", last_at, ndone); end
  endtask

  task automatic test_abort;
    int bad;
    fill(32'd0);
    run_poly(1'b1, 1'b0, 100, 1'b0);
    checks++; if (any_last != 0 || ndone != 0) begin errors++; $display("FAIL abort last=%0d done=%0d want 0 0", any_last, ndone); end
    checks++; if (busy !== 1'b0 || bus.byte_valid !== 1'b0) begin errors++; $display("FAIL abort idle busy=%b bv=%b want 0 0", busy, bus.byte_valid); end
    run_poly(1'b0, 1'b0, 0, 1'b0);
    bad = 0;
    for (int i = 0; i < 576; i++) if (got[i] !== pat17(i)) bad++;
    checks++; if (bad != 0 || nbytes != 576 || last_at != 575 || ndone != 1) begin errors++; $display("FAIL after_abort bad=%0d n=%0d last=%0d done=%0d want 0 576 575 1", bad, nbytes, last_at, ndone); end
  endtask

`ifdef POLYZ_RANGE_CHECK_EN
  task automatic test_range;
    fill(32'd0);
    coefs[5] = 32'h0002_0001;
    run_poly(1'b0, 1'b0, 0, 1'b0);
    checks++; if (rng_seen - rng_hs != 1) begin errors++; $display("FAIL range_timing got %0d want 1", rng_seen - rng_hs); end
    checks++; if (nbytes != 576 || ndone != 1) begin errors++; $display("FAIL range_bytes n=%0d done=%0d want 576 1", nbytes, ndone); end
    checks++; if (range_err !== 1'b1) begin errors++; $display("FAIL range_sticky got %b want 1", range_err); end
    fill(32'd0);
    run_poly(1'b0, 1'b0, 0, 1'b0);
    checks++; if (rng_seen >= 0 || range_err !== 1'b0) begin errors++; $display("FAIL range_clear seen=%0d err=%b want -1 0", rng_seen, range_err); end
  endtask
`endif

  initial begin
    test_reset;
    test_g19_zero;
    test_g17_zero;
    test_extremes;
    test_backpressure;
    test_abort;
`ifdef POLYZ_RANGE_CHECK_EN
    test_range;
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
